// File: rtl/scope_capture_ctrl_if.sv
// Bus bundle between the oscilloscope capture controller and its
// surroundings: audio sample feed, video timing, and both RAM ports.
interface scope_capture_ctrl_if #(
  parameter int SAMPLE_W = 16,
  parameter int ADDR_W   = 10
);
  // Audio side
  logic                       sample_valid;
  logic signed [SAMPLE_W-1:0] sample_data;
  logic [3:0]                 decim;

  // Video side
  logic                       frame_start;
  logic [9:0]                 rd_x;
  logic                       rd_active;

  // RAM write port (back bank)
  logic                       wr_en;
  logic                       wr_bank;
  logic [ADDR_W-1:0]          wr_addr;
  logic signed [SAMPLE_W-1:0] wr_data;

  // RAM read port (front bank)
  logic                       rd_en;
  logic                       rd_bank;
  logic [ADDR_W-1:0]          rd_addr;

  // Status
  logic                       frame_swapped;
  logic                       forced_trig;

  // Environment side: drives samples and video timing, observes the RAM ports
  modport master (
    output sample_valid, sample_data, decim, frame_start, rd_x, rd_active,
    input  wr_en, wr_bank, wr_addr, wr_data, rd_en, rd_bank, rd_addr,
           frame_swapped, forced_trig
  );

  // Controller side
  modport slave (
    input  sample_valid, sample_data, decim, frame_start, rd_x, rd_active,
    output wr_en, wr_bank, wr_addr, wr_data, rd_en, rd_bank, rd_addr,
           frame_swapped, forced_trig
  );
endinterface

// File: rtl/scope_capture_ctrl.sv
// Capture controller for the double-banked oscilloscope waveform RAM.
// Audio samples are trigger-aligned and decimated into the back bank while
// the video side reads the front bank by pixel column. Banks swap only at a
// frame start after a complete capture, so the displayed trace never tears.
module scope_capture_ctrl #(
  parameter int SAMPLE_W     = 16,
  parameter int DEPTH        = 800,
  parameter int ADDR_W       = 10,
  parameter int TRIG_TIMEOUT = 48000
) (
  input logic                 clk,
  input logic                 rst_n,
  scope_capture_ctrl_if.slave bus
);

  localparam int                TO_W      = (TRIG_TIMEOUT > 2) ? $clog2(TRIG_TIMEOUT) : 1;
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TRIG_TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [31:0]       DEPTH_32  = 32'(DEPTH);

  typedef enum logic [1:0] {ARM, CAPTURE, DONE} state_t;

  state_t state, state_nxt;

  // Trigger / capture bookkeeping
  logic                prev_neg;
  logic [TO_W-1:0]     to_cnt;
  logic [3:0]          dec_cnt;
  logic [3:0]          decim_lat;
  logic [ADDR_W-1:0]   wr_ptr;

  // Per-cycle events decoded from the current state
  logic                sample_msb;
  logic                rising;
  logic                trigger;
  logic                forced_evt;
  logic                cap_write;
  logic                last_write;
  logic                swap;
  logic                do_write;
  logic [ADDR_W-1:0]   next_addr;

  // Registered outputs
  logic                       wr_en_q;
  logic [ADDR_W-1:0]          wr_addr_q;
  logic signed [SAMPLE_W-1:0] wr_data_q;
  logic                       rd_en_q;
  logic [ADDR_W-1:0]          rd_addr_q;
  logic                       rd_bank_q;
  logic                       frame_swapped_q;
  logic                       forced_trig_q;

  assign sample_msb = bus.sample_data[SAMPLE_W-1];
  assign rising     = prev_neg && !sample_msb;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ARM;
    else        state <= state_nxt;
  end

  // Next-state logic: arm -> capture on trigger, capture -> done after the
  // last word, done -> arm only when the banks swap at frame start
  always_comb begin
    state_nxt = state;
    case (state)
      ARM:     if (trigger)    state_nxt = CAPTURE;
      CAPTURE: if (last_write) state_nxt = DONE;
      DONE:    if (swap)       state_nxt = ARM;
      default:                 state_nxt = ARM;
    endcase
  end

  // Event decode: which sample is accepted, where it goes, and when to swap
  always_comb begin
    trigger    = 1'b0;
    forced_evt = 1'b0;
    cap_write  = 1'b0;
    last_write = 1'b0;
    swap       = 1'b0;
    do_write   = 1'b0;
    next_addr  = wr_ptr;
    case (state)
      ARM: begin
        if (bus.sample_valid && (rising || to_cnt == TO_LAST)) begin
          trigger    = 1'b1;
          forced_evt = !rising;
          do_write   = 1'b1;
          next_addr  = '0;
        end
      end
      CAPTURE: begin
        if (bus.sample_valid && dec_cnt == decim_lat) begin
          cap_write  = 1'b1;
          do_write   = 1'b1;
          last_write = (wr_ptr == ADDR_LAST);
        end
      end
      DONE: begin
        swap = bus.frame_start;
      end
      default: begin
        swap = 1'b0;
      end
    endcase
  end

  // Sign history of the raw stream, kept in every state for crossing detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                prev_neg <= 1'b0;
    else if (bus.sample_valid) prev_neg <= sample_msb;
  end

  // Timeout counter: counts raw samples while armed, restarts on each arm
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  to_cnt <= '0;
    else if (trigger || swap)                    to_cnt <= '0;
    else if (state == ARM && bus.sample_valid)   to_cnt <= to_cnt + TO_W'(1);
  end

  // Decimation: ratio is frozen at the trigger so a mid-capture change
  // cannot stretch or squeeze the trace
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_cnt   <= '0;
      decim_lat <= '0;
    end else if (trigger) begin
      dec_cnt   <= '0;
      decim_lat <= bus.decim;
    end else if (state == CAPTURE && bus.sample_valid) begin
      dec_cnt   <= (dec_cnt == decim_lat) ? 4'd0 : dec_cnt + 4'd1;
    end
  end

  // Write pointer: the trigger sample takes address 0, captures follow on
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         wr_ptr <= '0;
    else if (trigger)   wr_ptr <= ADDR_W'(1);
    else if (cap_write) wr_ptr <= wr_ptr + ADDR_W'(1);
  end

  // RAM write port, one cycle behind the accepted sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= do_write;
      if (do_write) begin
        wr_addr_q <= next_addr;
        wr_data_q <= bus.sample_data;
      end
    end
  end

  // Bank select, swap pulse and sticky forced-trigger flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_bank_q       <= 1'b0;
      frame_swapped_q <= 1'b0;
      forced_trig_q   <= 1'b0;
    end else begin
      frame_swapped_q <= swap;
      if (swap)    rd_bank_q     <= ~rd_bank_q;
      if (trigger) forced_trig_q <= forced_evt;
    end
  end

  // Read port: pixel column to front-bank address, columns past the trace
  // width are never read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
    end else begin
      rd_addr_q <= bus.rd_x[ADDR_W-1:0];
      rd_en_q   <= bus.rd_active && (32'(bus.rd_x) < DEPTH_32);
    end
  end

  assign bus.wr_en         = wr_en_q;
  assign bus.wr_bank       = ~rd_bank_q;
  assign bus.wr_addr       = wr_addr_q;
  assign bus.wr_data       = wr_data_q;
  assign bus.rd_en         = rd_en_q;
  assign bus.rd_bank       = rd_bank_q;
  assign bus.rd_addr       = rd_addr_q;
  assign bus.frame_swapped = frame_swapped_q;
  assign bus.forced_trig   = forced_trig_q;

endmodule
